muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage, beside the ALU. Takes forwarded operands and func3 of an M-extension instruction, runs a multi-cycle radix-2 algorithm, and returns a 32-bit result for the EX_MEM register. It raises a stall request that freezes PC, IF_ID and ID_EX until the result is ready.

---
 rtl/muldiv_if.sv | 26 ++
 rtl/muldiv_unit.sv | 164 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_if.sv
// muldiv_if: EX-stage request/response bundle for the RV32M multiply/divide unit.
// The pipeline side (master) drives the operands and control; the unit (slave)
// returns status and result.
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            Start;
    logic [2:0]      func3;
    logic [XLEN-1:0] Op_A;
    logic [XLEN-1:0] Op_B;
    logic            Flush;
    logic            Busy;
    logic            Done;
    logic [XLEN-1:0] Result;
    logic            Stall;

    modport master (
        output Start, func3, Op_A, Op_B, Flush,
        input  Busy, Done, Result, Stall
    );

    modport slave (
        input  Start, func3, Op_A, Op_B, Flush,
        output Busy, Done, Result, Stall
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit beside the ALU.
// Radix-2 shift-add multiply and restoring divide on magnitudes, one bit per
// cycle for 32 cycles, then a sign-fix cycle. Divide-by-zero and signed
// overflow are answered at the accept edge.
// Optional feature macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle
// 33x33 signed multiplier and finish at the accept edge; divide is unchanged.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic      Clk,
    input  logic      Rst,
    muldiv_if.slave   bus
);
    localparam int CW = $clog2(XLEN);

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic [2:0]        f3_r;
    logic [XLEN-1:0]   mag_b;
    logic              neg_q, neg_r;
    logic [2*XLEN-1:0] prod;      // multiply: {hi, lo}; divide: lo holds dividend/quotient
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   result_r;
    logic              done_r;

    logic              accept, short_cut, div_zero, div_ovf;
    logic              a_signed, b_signed, sign_a, sign_b;
    logic [XLEN-1:0]   abs_a, abs_b, short_val, fix_val;
    logic [XLEN:0]     mul_sum, div_sh, div_tr;
    logic              div_ok;
    logic [2*XLEN-1:0] prod_fix;

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN+1:0] fast_prod;
`endif

    // Operand decode, magnitudes and the accept-edge short-circuit result
    always_comb begin
        a_signed  = (bus.func3 == F_MULH) || (bus.func3 == F_MULHSU) ||
                    (bus.func3 == F_DIV)  || (bus.func3 == F_REM);
        b_signed  = (bus.func3 == F_MULH) || (bus.func3 == F_DIV) || (bus.func3 == F_REM);
        sign_a    = a_signed & bus.Op_A[XLEN-1];
        sign_b    = b_signed & bus.Op_B[XLEN-1];
        abs_a     = sign_a ? -bus.Op_A : bus.Op_A;
        abs_b     = sign_b ? -bus.Op_B : bus.Op_B;
        accept    = (state == IDLE) && bus.Start && !done_r && !bus.Flush;
        div_zero  = bus.func3[2] && (bus.Op_B == '0);
        div_ovf   = ((bus.func3 == F_DIV) || (bus.func3 == F_REM)) &&
                    (bus.Op_A == {1'b1, {(XLEN-1){1'b0}}}) && (bus.Op_B == '1);
        short_cut = 1'b0;
        short_val = '0;
`ifdef MULDIV_FAST_MUL_EN
        fast_prod = $signed({sign_a, bus.Op_A}) * $signed({sign_b, bus.Op_B});
`endif
        if (div_zero) begin
            short_cut = 1'b1;
            short_val = bus.func3[1] ? bus.Op_A : '1;
        end else if (div_ovf) begin
            short_cut = 1'b1;
            short_val = bus.func3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
`ifdef MULDIV_FAST_MUL_EN
        else if (!bus.func3[2]) begin
            short_cut = 1'b1;
            short_val = (bus.func3 == F_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
        end
`endif
    end

    // One radix-2 step for each algorithm, plus final sign fix and result select
    always_comb begin
        mul_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mag_b} : '0);
        div_sh   = {rem, prod[XLEN-1]};
        div_tr   = div_sh - {1'b0, mag_b};
        div_ok   = !div_tr[XLEN];
        prod_fix = neg_q ? -prod : prod;
        case (f3_r)
            3'b000:                 fix_val = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_val = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_val = neg_q ? -prod[XLEN-1:0] : prod[XLEN-1:0];
            default:                fix_val = neg_r ? -rem : rem;
        endcase
    end

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Rst) state <= IDLE;
        else     state <= state_nx;
    end

    // FSM next state; Flush aborts from anywhere
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && !short_cut) state_nx = CALC;
            CALC:    if (cnt == CW'(XLEN-1))   state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (bus.Flush) state_nx = IDLE;
    end

    // Datapath: latch operands, iterate, register result and the Done pulse
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt      <= '0;
            f3_r     <= '0;
            mag_b    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            prod     <= '0;
            rem      <= '0;
            result_r <= '0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (!bus.Flush) begin
                case (state)
                    IDLE: if (accept) begin
                        if (short_cut) begin
                            result_r <= short_val;
                            done_r   <= 1'b1;
                        end else begin
                            f3_r  <= bus.func3;
                            mag_b <= abs_b;
                            prod  <= {{XLEN{1'b0}}, abs_a};
                            rem   <= '0;
                            cnt   <= '0;
                            neg_q <= sign_a ^ sign_b;
                            neg_r <= sign_a;
                        end
                    end
                    CALC: begin
                        cnt <= cnt + 1'b1;
                        if (f3_r[2]) begin
                            rem              <= div_ok ? div_tr[XLEN-1:0] : div_sh[XLEN-1:0];
                            prod[XLEN-1:0]   <= {prod[XLEN-2:0], div_ok};
                        end else begin
                            prod <= {mul_sum, prod[XLEN-1:1]};
                        end
                    end
                    FIX: begin
                        result_r <= fix_val;
                        done_r   <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.Busy   = (state != IDLE);
    assign bus.Done   = done_r;
    assign bus.Result = result_r;
    assign bus.Stall  = bus.Busy | (bus.Start & ~done_r);
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vector table, hand sequences for reset/flush/back-to-back,
// and random operations checked against an arithmetic reference model.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_CYC = 1;
`else
    localparam int MUL_CYC = 34;
`endif
    localparam int LONG_CYC = 34;

    muldiv_if #(.XLEN(32)) bus ();
    muldiv_unit #(.XLEN(32)) dut (.Clk(clk), .Rst(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          cyc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: RV32M semantics from plain 64-bit arithmetic
    function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] ps;
        logic [63:0]        pu;
        int                 sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        case (f)
            3'd0: begin pu = {32'b0, a} * {32'b0, b}; return pu[31:0]; end
            3'd1: begin ps = 64'(sa) * 64'(sb); return ps[63:32]; end
            3'd2: begin ps = 64'(sa) * $signed({32'b0, b}); return ps[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; return pu[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_cyc(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return MUL_CYC;
        if (b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return LONG_CYC;
    endfunction

    // Drive an op now (between edges) and wait for Done; counts cycles with Stall high
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output int cyc, output int stl);
        bus.Start = 1'b1;
        bus.func3 = f;
        bus.Op_A  = a;
        bus.Op_B  = b;
        cyc = 0;
        #1;
        stl = bus.Stall ? 1 : 0;
        r   = bus.Result;
        for (int k = 1; k <= 60 && cyc == 0; k++) begin
            @(negedge clk); #1;
            if (bus.Done) begin
                cyc = k;
                r   = bus.Result;
            end else if (bus.Stall) begin
                stl++;
            end
        end
    endtask

    task automatic finish_op(input string name);
        bus.Start = 1'b0;
        @(negedge clk); #1;
        chk({name, "_done_single"}, 32'(bus.Done), 32'd0);
    endtask

    task automatic check_op(input string name, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] er, input int ec);
        logic [31:0] r;
        int          cyc, stl;
        run_op(f, a, b, r, cyc, stl);
        chk({name, "_result"}, r, er);
        chk({name, "_latency"}, 32'(cyc), 32'(ec));
        chk({name, "_stall_cycles"}, 32'(stl), 32'(ec));
        chk({name, "_busy_at_done"}, 32'(bus.Busy), 32'd0);
        finish_op(name);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        vec_t        tbl [13];
        logic [31:0] r, a, b;
        logic [2:0]  f;
        int          cyc, stl;
        bit          seen;

        tbl[0]  = '{3'd0, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, MUL_CYC};
        tbl[1]  = '{3'd1, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, MUL_CYC};
        tbl[2]  = '{3'd3, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, MUL_CYC};
        tbl[3]  = '{3'd2, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, MUL_CYC};
        tbl[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, LONG_CYC};
        tbl[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, LONG_CYC};
        tbl[6]  = '{3'd5, 32'd100,       32'd7, 32'd14,        LONG_CYC};
        tbl[7]  = '{3'd7, 32'd100,       32'd7, 32'd2,         LONG_CYC};
        tbl[8]  = '{3'd4, 32'd5,         32'd0, 32'hFFFF_FFFF, 1};
        tbl[9]  = '{3'd7, 32'd5,         32'd0, 32'd5,         1};
        tbl[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        tbl[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1};
        tbl[12] = '{3'd6, 32'd5,         32'd0, 32'd5,         1};

        rst = 1'b1;
        bus.Start = 1'b0; bus.func3 = 3'd0; bus.Op_A = '0; bus.Op_B = '0; bus.Flush = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_busy", 32'(bus.Busy), 32'd0);
        chk("reset_done", 32'(bus.Done), 32'd0);
        chk("reset_result", bus.Result, 32'd0);
        chk("reset_stall", 32'(bus.Stall), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed table
        foreach (tbl[i])
            check_op($sformatf("vec%0d", i), tbl[i].f, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].cyc);

        // Reset mid-operation: MUL 7x6, Rst sampled at E10
        bus.Start = 1'b1; bus.func3 = 3'd0; bus.Op_A = 32'd7; bus.Op_B = 32'd6;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        rst = 1'b1;
        bus.Start = 1'b0;
        @(negedge clk); #1;
        chk("midrst_busy", 32'(bus.Busy), 32'd0);
        chk("midrst_done", 32'(bus.Done), 32'd0);
        chk("midrst_result", bus.Result, 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            if (bus.Done) seen = 1'b1;
        end
        chk("midrst_no_done", 32'(seen), 32'd0);

        // Flush at E15 of a DIVU: establish a known Result first
        check_op("pre_flush", 3'd5, 32'd100, 32'd7, 32'd14, LONG_CYC);
        bus.Start = 1'b1; bus.func3 = 3'd5; bus.Op_A = 32'd1000; bus.Op_B = 32'd3;
        seen = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk); #1;
            if (bus.Done) seen = 1'b1;
        end
        bus.Flush = 1'b1;
        bus.Start = 1'b0;
        @(negedge clk); #1;
        chk("flush_busy", 32'(bus.Busy), 32'd0);
        chk("flush_done", 32'(bus.Done | seen), 32'd0);
        chk("flush_result_kept", bus.Result, 32'd14);
        bus.Flush = 1'b0;
        check_op("post_flush", 3'd5, 32'd1000, 32'd3, 32'd333, LONG_CYC);

        // Back-to-back: DIVU 9/3 then MULHU 0x80000000 x 4 with Start held
        run_op(3'd5, 32'd9, 32'd3, r, cyc, stl);
        chk("b2b_first_result", r, 32'd3);
        chk("b2b_first_latency", 32'(cyc), 32'(LONG_CYC));
        bus.func3 = 3'd3; bus.Op_A = 32'h8000_0000; bus.Op_B = 32'd4;
        @(negedge clk); #1;
        chk("b2b_gap_done", 32'(bus.Done), 32'd0);
        chk("b2b_gap_busy", 32'(bus.Busy), 32'd0);
        chk("b2b_gap_stall", 32'(bus.Stall), 32'd1);
        run_op(3'd3, 32'h8000_0000, 32'd4, r, cyc, stl);
        chk("b2b_second_result", r, 32'd2);
        chk("b2b_second_latency", 32'(cyc), 32'(MUL_CYC));
        finish_op("b2b");

        // Random operations against the reference model
        for (int n = 0; n < 80; n++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run_op(f, a, b, r, cyc, stl);
            chk($sformatf("rnd%0d_f%0d_%h_%h", n, f, a, b), r, ref_res(f, a, b));
            chk($sformatf("rnd%0d_latency", n), 32'(cyc), 32'(ref_cyc(f, a, b)));
            finish_op($sformatf("rnd%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
